// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: req/ack front end for the data RAM, IO channels and cycle counter.
// One access in flight; RAM accesses are stretched by LATENCY wait states.
//
//   state  | meaning
//   S_IDLE | waiting for req; latches the access when it arrives
//   S_WAIT | RAM wait states counting down
//   S_DONE | access committed, ack high for one cycle
module mem_io_ctrl #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2,
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     we,
    input  logic [31:0]              addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     ack,
    input  logic [NUM_IN*WIDTH-1:0]  gpio_in,
    output logic [NUM_OUT*WIDTH-1:0] gpio_out
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [5:0] SEL_CNT = 6'd31;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic [1:0]          rst_sync;
    logic                rst_int;
    logic [NUM_IN*WIDTH-1:0] in_meta;
    logic [NUM_IN*WIDTH-1:0] in_sync;
    logic [31:0]         cyc_cnt;
    logic [WIDTH-1:0]    mem [DEPTH];

    logic                q_we;
    logic                q_io;
    logic [5:0]          q_sel;
    logic [AW-1:0]       q_idx;
    logic [WIDTH-1:0]    q_wdata;

    logic                cur_we;
    logic                cur_io;
    logic [5:0]          cur_sel;
    logic [AW-1:0]       cur_idx;
    logic [WIDTH-1:0]    cur_wdata;

    logic                go_done;
    logic                mem_we;
    logic [WIDTH-1:0]    rd_val;
    logic                unused_addr;

    assign unused_addr = ^addr;

    // Reset asserts asynchronously but releases on clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int = rst_sync[1];

    // In IDLE the access decodes straight from the bus so IO and zero-latency
    // RAM accesses can commit on the same edge that samples req.
    always_comb begin
        if (state == S_IDLE) begin
            cur_we    = we;
            cur_io    = addr[11];
            cur_sel   = addr[7:2];
            cur_idx   = addr[AW+1:2];
            cur_wdata = wdata;
        end else begin
            cur_we    = q_we;
            cur_io    = q_io;
            cur_sel   = q_sel;
            cur_idx   = q_idx;
            cur_wdata = q_wdata;
        end
    end

    assign go_done = ((state == S_IDLE) && req && (cur_io || (LATENCY == 0))) ||
                     ((state == S_WAIT) && (cnt == 4'd1));
    assign mem_we  = rst_int && go_done && cur_we && !cur_io;

    always_comb begin
        rd_val = '0;
        if (!cur_io) begin
            rd_val = mem[cur_idx];
        end else begin
            for (int k = 0; k < NUM_IN; k++)
                if (cur_sel == 6'(k)) rd_val = in_sync[k*WIDTH +: WIDTH];
            for (int k = 0; k < NUM_OUT; k++)
                if (cur_sel == 6'(16 + k)) rd_val = gpio_out[k*WIDTH +: WIDTH];
            if (cur_sel == SEL_CNT) rd_val = WIDTH'(cyc_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ack     <= 1'b0;
            rdata   <= '0;
            q_we    <= 1'b0;
            q_io    <= 1'b0;
            q_sel   <= '0;
            q_idx   <= '0;
            q_wdata <= '0;
        end else begin
            ack <= go_done;
            if (go_done && !cur_we) rdata <= rd_val;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        q_we    <= cur_we;
                        q_io    <= cur_io;
                        q_sel   <= cur_sel;
                        q_idx   <= cur_idx;
                        q_wdata <= cur_wdata;
                        if (go_done) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'(LATENCY);
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[cur_idx] <= cur_wdata;
    end

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            gpio_out <= '0;
        end else if (go_done && cur_we && cur_io) begin
            for (int k = 0; k < NUM_OUT; k++)
                if (cur_sel == 6'(16 + k)) gpio_out[k*WIDTH +: WIDTH] <= cur_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            in_meta <= '0;
            in_sync <= '0;
        end else begin
            in_meta <= gpio_in;
            in_sync <= in_meta;
        end
    end

    // A clearing write wins over the increment on its commit edge.
    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int)
            cyc_cnt <= '0;
        else if (go_done && cur_we && cur_io && (cur_sel == SEL_CNT))
            cyc_cnt <= '0;
        else
            cyc_cnt <= cyc_cnt + 32'd1;
    end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb_mem_io_ctrl: table vectors, randomized accesses against an address-map model,
// and hand sequences for the counter, reset mid-access and latency extremes.
module tb_mem_io_ctrl;
    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        req_v;
    logic              we;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [2:0][31:0]  rdata_v;
    logic [2:0]        ack_v;
    logic [127:0]      gpio_in;
    logic [2:0][127:0] gpio_out_v;

    int n_cmp = 0;
    int n_err = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    mem_io_ctrl #(.WIDTH(32), .DEPTH(64), .LATENCY(2), .NUM_IN(4), .NUM_OUT(4)) dut (
        .clk(clk), .rst(rst), .req(req_v[0]), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata_v[0]), .ack(ack_v[0]), .gpio_in(gpio_in), .gpio_out(gpio_out_v[0]));
    mem_io_ctrl #(.WIDTH(32), .DEPTH(64), .LATENCY(0), .NUM_IN(4), .NUM_OUT(4)) dut_l0 (
        .clk(clk), .rst(rst), .req(req_v[1]), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata_v[1]), .ack(ack_v[1]), .gpio_in(gpio_in), .gpio_out(gpio_out_v[1]));
    mem_io_ctrl #(.WIDTH(32), .DEPTH(64), .LATENCY(15), .NUM_IN(4), .NUM_OUT(4)) dut_l15 (
        .clk(clk), .rst(rst), .req(req_v[2]), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata_v[2]), .ack(ack_v[2]), .gpio_in(gpio_in), .gpio_out(gpio_out_v[2]));

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        int          lat;
    } vec_t;
    vec_t tbl [12];

    // Reference state for the LATENCY=2 instance
    logic [31:0] ram_m [64];
    bit          ram_v [64];
    logic [31:0] out_m [4];
    logic [31:0] gin_m [4];
    logic [31:0] last_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
        end
    endtask

    // Called at a negedge with the selected instance idle; returns at a negedge.
    task automatic access(input int inst, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd,
                          output int lat, output int done_edge);
        int n;
        bit seen;
        addr = a; we = w; wdata = d;
        req_v[inst] = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ack_v[inst]) seen = 1;
        end
        req_v[inst] = 1'b0;
        rd = rdata_v[inst];
        lat = n;
        done_edge = edge_cnt;
        @(posedge clk);
        @(negedge clk);
        check("ack_single_pulse", {31'b0, ack_v[inst]}, 32'd0);
    endtask

    task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] exp_rd, output int exp_lat);
        int s;
        s = int'(a[7:2]);
        if (!a[11]) begin
            exp_lat = 3;
            if (w) begin
                ram_m[s] = d;
                ram_v[s] = 1;
            end else begin
                last_rd = ram_m[s];
            end
        end else begin
            exp_lat = 1;
            if (w) begin
                if (s >= 16 && s < 20) out_m[s-16] = d;
            end else if (s < 4) begin
                last_rd = gin_m[s];
            end else if (s >= 16 && s < 20) begin
                last_rd = out_m[s-16];
            end else begin
                last_rd = 32'd0;
            end
        end
        exp_rd = last_rd;
    endtask

    task automatic check_outs(input string tag);
        for (int k = 0; k < 4; k++)
            check($sformatf("%s_gpio_out%0d", tag, k), gpio_out_v[0][k*32 +: 32], out_m[k]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, erd, c1, c2, c3;
        int          lat, elat, de, e1, e2, ec, er;
        logic        w;
        logic [31:0] a, d;
        int          op, word, s;

        rst = 1'b0;
        req_v = '0;
        we = 1'b0;
        addr = '0;
        wdata = '0;
        gpio_in = {32'h0000_3234, 32'h0000_2234, 32'h0000_1234, 32'h0000_0234};
        for (int k = 0; k < 4; k++) begin
            gin_m[k] = gpio_in[k*32 +: 32];
            out_m[k] = '0;
        end
        for (int k = 0; k < 64; k++) ram_v[k] = 0;
        last_rd = '0;

        tbl[0]  = '{1'b1, 32'h000, 32'hDEAD_BEEF, 32'h0000_0000, 3};
        tbl[1]  = '{1'b0, 32'h000, 32'h0,         32'hDEAD_BEEF, 3};
        tbl[2]  = '{1'b0, 32'h100, 32'h0,         32'hDEAD_BEEF, 3};
        tbl[3]  = '{1'b1, 32'h840, 32'h0000_00A5, 32'hDEAD_BEEF, 1};
        tbl[4]  = '{1'b0, 32'h840, 32'h0,         32'h0000_00A5, 1};
        tbl[5]  = '{1'b0, 32'h804, 32'h0,         32'h0000_1234, 1};
        tbl[6]  = '{1'b0, 32'h820, 32'h0,         32'h0000_0000, 1};
        tbl[7]  = '{1'b1, 32'h800, 32'h0000_0005, 32'h0000_0000, 1};
        tbl[8]  = '{1'b0, 32'h800, 32'h0,         32'h0000_0234, 1};
        tbl[9]  = '{1'b1, 32'h00C, 32'h0000_0022, 32'h0000_0234, 3};
        tbl[10] = '{1'b0, 32'h00C, 32'h0,         32'h0000_0022, 3};
        tbl[11] = '{1'b0, 32'h40F, 32'h0,         32'h0000_0022, 3};

        repeat (3) @(negedge clk);
        check("reset_ack", {31'b0, ack_v[0]}, 32'd0);
        check("reset_rdata", rdata_v[0], 32'd0);
        check("reset_gpio_out0", gpio_out_v[0][31:0], 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            access(0, tbl[i].w, tbl[i].a, tbl[i].d, rd, lat, de);
            model(tbl[i].w, tbl[i].a, tbl[i].d, erd, elat);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
            check($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
        end
        check("tbl_gpio_out0", gpio_out_v[0][31:0], 32'h0000_00A5);
        check("tbl_gpio_out1", gpio_out_v[0][63:32], 32'd0);

        for (int i = 0; i < 60; i++) begin
            if (i == 30) begin
                gpio_in = {$urandom, $urandom, $urandom, $urandom};
                for (int k = 0; k < 4; k++) gin_m[k] = gpio_in[k*32 +: 32];
                repeat (3) @(negedge clk);
            end
            op = $urandom_range(0, 3);
            d = $urandom;
            if (op <= 1) begin
                word = $urandom_range(0, 63);
                w = (op == 0) || !ram_v[word];
                a = {20'($urandom), 1'b0, 3'($urandom), 6'(word), 2'($urandom)};
            end else begin
                if (op == 2) s = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(16, 19);
                else s = $urandom_range(0, 63);
                if (s == 31) s = 30;
                w = 1'($urandom);
                a = {20'($urandom), 1'b1, 3'($urandom), 6'(s), 2'($urandom)};
            end
            model(w, a, d, erd, elat);
            access(0, w, a, d, rd, lat, de);
            check($sformatf("rnd%0d_rdata", i), rd, erd);
            check($sformatf("rnd%0d_lat", i), lat, elat);
            check_outs($sformatf("rnd%0d", i));
        end

        access(0, 1'b0, 32'h87C, 32'h0, c1, lat, e1);
        check("cnt_lat", lat, 32'd1);
        check("cnt_nonzero", {31'b0, (c1 != 32'd0)}, 32'd1);
        access(0, 1'b0, 32'h87C, 32'h0, c2, lat, e2);
        check("cnt_step", c2 - c1, 32'(e2 - e1));
        access(0, 1'b1, 32'h87C, 32'hFFFF_FFFF, rd, lat, ec);
        check("cnt_wr_rdata_hold", rd, c2);
        repeat ($urandom_range(0, 5)) @(negedge clk);
        access(0, 1'b0, 32'h87C, 32'h0, c3, lat, er);
        check("cnt_after_clear", c3, 32'(er - ec - 1));

        access(0, 1'b1, 32'h840, 32'h0000_00A5, rd, lat, de);
        access(0, 1'b1, 32'h00C, 32'h0000_0022, rd, lat, de);
        addr = 32'h00C; we = 1'b1; wdata = 32'h0000_0011;
        req_v[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rst_mid_ack_wait", {31'b0, ack_v[0]}, 32'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        req_v[0] = 1'b0;
        #1;
        check("rst_mid_rdata", rdata_v[0], 32'd0);
        check("rst_mid_gpio_out0", gpio_out_v[0][31:0], 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_mid_no_ack", {31'b0, ack_v[0]}, 32'd0);
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_no_ack", {31'b0, ack_v[0]}, 32'd0);
        check("post_rst_gpio_out0", gpio_out_v[0][31:0], 32'd0);
        access(0, 1'b0, 32'h00C, 32'h0, rd, lat, de);
        check("post_rst_word3", rd, 32'h0000_0022);
        check("post_rst_lat", lat, 32'd3);

        for (int inst = 1; inst <= 2; inst++) begin
            elat = (inst == 1) ? 1 : 16;
            access(inst, 1'b1, 32'h010, 32'hCAFE_0000 + 32'(inst), rd, lat, de);
            check($sformatf("sweep%0d_wr_lat", inst), lat, elat);
            access(inst, 1'b0, 32'h010, 32'h0, rd, lat, de);
            check($sformatf("sweep%0d_rd_data", inst), rd, 32'hCAFE_0000 + 32'(inst));
            check($sformatf("sweep%0d_rd_lat", inst), lat, elat);
            access(inst, 1'b0, 32'h804, 32'h0, rd, lat, de);
            check($sformatf("sweep%0d_io_data", inst), rd, gin_m[1]);
            check($sformatf("sweep%0d_io_lat", inst), lat, 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
